// File: rtl/control_acceso_parqueo.sv
// -----------------------------------------------------------------------------
// control_acceso_parqueo
//   Parking-gate access controller. It detects a vehicle waiting at the gate and
//   checks a PIN on each rising edge of enterPin. A correct PIN opens the gate.
//   Repeated wrong PINs raise an alarm. If a second vehicle tailgates through the
//   open gate, the controller locks out until a correct PIN is entered.
//
// Ports
//   Clk       in   1      clock, rising edge
//   Reset     in   1      asynchronous, active-high
//   Vehiculo  in   1      vehicle present at the gate entry
//   Termino   in   1      vehicle finished passing (one-cycle pulse)
//   enterPin  in   1      PIN submit level; only its rising edge counts
//   Pin       in   W_PIN  PIN value, looked at only in a strobe cycle
//   Cerrado   out  1      gate closed
//   Abierto   out  1      gate open
//   Alarma    out  1      wrong-PIN or tailgate alarm
//   Bloqueo   out  1      tailgate lockout
// -----------------------------------------------------------------------------
module control_acceso_parqueo #(
  parameter int               W_PIN        = 8,
  parameter logic [W_PIN-1:0] PIN_CORRECTO = 8'b00010000,
  parameter int               MAX_INTENTOS = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             enterPin,
  input  logic [W_PIN-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo
);

  localparam int            CW    = $clog2(MAX_INTENTOS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INTENTOS);

  typedef enum logic [2:0] {
    CERRADO = 3'd0,
    ESPERA  = 3'd1,
    ABIERTO = 3'd2,
    ALARMA  = 3'd3,
    BLOQUEO = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic [CW-1:0] intentos_q, intentos_d;
  logic          enter_q;
  logic          cerrado_q, abierto_q, alarma_q, bloqueo_q;
  logic          cerrado_d, abierto_d, alarma_d, bloqueo_d;

  logic          strobe;
  logic          pin_ok;
  logic [CW-1:0] intentos_inc;

  // A held enterPin must count only once, so only its rising edge is used.
  assign strobe = enterPin & ~enter_q;
  assign pin_ok = (Pin == PIN_CORRECTO);

  // The counter saturates and never wraps, even if wrong PINs keep arriving in ALARMA.
  assign intentos_inc = (intentos_q == MAX_C) ? MAX_C : intentos_q + CW'(1);

  // Next-state and wrong-PIN counter logic.
  always_comb begin
    state_d    = state_q;
    intentos_d = intentos_q;
    case (state_q)
      CERRADO: begin
        if (Vehiculo) state_d = ESPERA;
        else          state_d = CERRADO;
      end
      ESPERA: begin
        // A vehicle leaving wins over a PIN entered in the same cycle.
        if (!Vehiculo) begin
          state_d    = CERRADO;
          intentos_d = '0;
        end else if (strobe && pin_ok) begin
          state_d    = ABIERTO;
          intentos_d = '0;
        end else if (strobe) begin
          intentos_d = intentos_inc;
          if (intentos_inc == MAX_C) state_d = ALARMA;
          else                       state_d = ESPERA;
        end else begin
          state_d = ESPERA;
        end
      end
      ALARMA: begin
        // The alarm stays on even if the vehicle leaves. Only a correct PIN clears it.
        if (strobe && pin_ok) begin
          state_d    = ABIERTO;
          intentos_d = '0;
        end else if (strobe) begin
          intentos_d = intentos_inc;
        end else begin
          state_d = ALARMA;
        end
      end
      ABIERTO: begin
        // A vehicle still present when the pass finishes means a second car tailgated.
        if (Termino && Vehiculo)  state_d = BLOQUEO;
        else if (Termino)         state_d = CERRADO;
        else                      state_d = ABIERTO;
      end
      BLOQUEO: begin
        if (strobe && pin_ok) begin
          state_d    = CERRADO;
          intentos_d = '0;
        end else begin
          state_d = BLOQUEO;
        end
      end
      default: begin
        state_d    = CERRADO;
        intentos_d = '0;
      end
    endcase
  end

  // Moore output decode of the next state, registered alongside the state.
  always_comb begin
    cerrado_d = 1'b1;
    abierto_d = 1'b0;
    alarma_d  = 1'b0;
    bloqueo_d = 1'b0;
    case (state_d)
      CERRADO, ESPERA: begin
        cerrado_d = 1'b1;
      end
      ABIERTO: begin
        cerrado_d = 1'b0;
        abierto_d = 1'b1;
      end
      ALARMA: begin
        alarma_d = 1'b1;
      end
      BLOQUEO: begin
        alarma_d  = 1'b1;
        bloqueo_d = 1'b1;
      end
      default: begin
        cerrado_d = 1'b1;
      end
    endcase
  end

  // State, counter, strobe history and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= CERRADO;
      intentos_q <= '0;
      enter_q    <= 1'b0;
      cerrado_q  <= 1'b1;
      abierto_q  <= 1'b0;
      alarma_q   <= 1'b0;
      bloqueo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      intentos_q <= intentos_d;
      enter_q    <= enterPin;
      cerrado_q  <= cerrado_d;
      abierto_q  <= abierto_d;
      alarma_q   <= alarma_d;
      bloqueo_q  <= bloqueo_d;
    end
  end

  assign Cerrado = cerrado_q;
  assign Abierto = abierto_q;
  assign Alarma  = alarma_q;
  assign Bloqueo = bloqueo_q;

endmodule
